// File: rtl/request_unit_ctrl.sv
// Request unit FSM: sequences fetch and data requests, latches halt, counts retired instructions.
// Define REQ_PERF_CNT_EN to add the istall_cnt/dstall_cnt stall counters.
module request_unit_ctrl #(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               CUdren,
  input  logic               CUdwen,
  input  logic               CUhalt,
  output logic               iren,
  output logic               dren,
  output logic               dwen,
  output logic               updatePC,
  output logic               halt,
  output logic               timeout,
  output logic [INSTR_W-1:0] instr_cnt
`ifdef REQ_PERF_CNT_EN
  ,
  output logic [31:0]        istall_cnt,
  output logic [31:0]        dstall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StData, StHalt} state_e;

  // MAX_WAIT == 0 disables the timeout; the limit value is then unused.
  localparam bit              TimeoutEn    = (MAX_WAIT != 0);
  localparam int unsigned     WaitLimitInt = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;
  localparam logic [WAIT_W-1:0] WaitLimit  = WAIT_W'(WaitLimitInt);

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_q;

  always_comb begin
    iren     = 1'b0;
    updatePC = 1'b0;
    case (state_q)
      StIdle: begin
        iren     = 1'b1;
        updatePC = ihit & ~CUhalt & ~CUdren & ~CUdwen;
      end
      StData:  updatePC = dhit;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      dren      <= 1'b0;
      dwen      <= 1'b0;
      halt      <= 1'b0;
      timeout   <= 1'b0;
      instr_cnt <= '0;
      wait_q    <= '0;
`ifdef REQ_PERF_CNT_EN
      istall_cnt <= '0;
      dstall_cnt <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (ihit) begin
            if (CUhalt) begin
              state_q <= StHalt;
              halt    <= 1'b1;
            end else if (CUdren | CUdwen) begin
              // A write takes priority when both request kinds are set.
              state_q <= StData;
              dwen    <= CUdwen;
              dren    <= ~CUdwen;
              wait_q  <= '0;
            end else begin
              instr_cnt <= instr_cnt + INSTR_W'(1);
            end
          end
        end
        StData: begin
          if (dhit) begin
            state_q   <= StIdle;
            dren      <= 1'b0;
            dwen      <= 1'b0;
            wait_q    <= '0;
            instr_cnt <= instr_cnt + INSTR_W'(1);
          end else begin
            if (wait_q != '1) wait_q <= wait_q + WAIT_W'(1);
            // Flag only; the request keeps being held until dhit.
            if (TimeoutEn && wait_q == WaitLimit) timeout <= 1'b1;
          end
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
`ifdef REQ_PERF_CNT_EN
      if (state_q == StIdle && !ihit && istall_cnt != '1) istall_cnt <= istall_cnt + 32'd1;
      if (state_q == StData && !dhit && dstall_cnt != '1) dstall_cnt <= dstall_cnt + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_request_unit_ctrl.sv
// Bench for request_unit_ctrl: directed vector table, hand sequences, and random run vs a model.
// Perf-counter checks are compiled in when REQ_PERF_CNT_EN is defined.
module tb_request_unit_ctrl;

  localparam int unsigned MW = 4;
  localparam int unsigned IW = 8;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, CUdren, CUdwen, CUhalt;
  logic iren, dren, dwen, updatePC, halt, timeout;
  logic [IW-1:0] instr_cnt;
`ifdef REQ_PERF_CNT_EN
  logic [31:0] istall_cnt, dstall_cnt;
`endif

  always #5 CLK = ~CLK;

  request_unit_ctrl #(.MAX_WAIT(MW), .INSTR_W(IW), .WAIT_W(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ihit     (ihit),
    .dhit     (dhit),
    .CUdren   (CUdren),
    .CUdwen   (CUdwen),
    .CUhalt   (CUhalt),
    .iren     (iren),
    .dren     (dren),
    .dwen     (dwen),
    .updatePC (updatePC),
    .halt     (halt),
    .timeout  (timeout),
    .instr_cnt(instr_cnt)
`ifdef REQ_PERF_CNT_EN
    ,
    .istall_cnt(istall_cnt),
    .dstall_cnt(dstall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: abstract view of the unit (halted / waiting on data / fetching).
  bit m_halted, m_busy, m_wr, m_to;
  int m_cnt, m_waited, m_istall, m_dstall;

  task automatic model_update();
    if (RST) begin
      m_halted = 0; m_busy = 0; m_wr = 0; m_to = 0;
      m_cnt = 0; m_waited = 0; m_istall = 0; m_dstall = 0;
    end else if (!m_halted) begin
      if (m_busy) begin
        if (dhit) begin
          m_busy = 0;
          m_cnt++;
        end else begin
          m_waited++;
          m_dstall++;
          if (MW != 0 && m_waited >= int'(MW)) m_to = 1;
        end
      end else if (ihit) begin
        if (CUhalt) m_halted = 1;
        else if (CUdren || CUdwen) begin
          m_busy = 1; m_wr = CUdwen; m_waited = 0;
        end else m_cnt++;
      end else m_istall++;
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // in = {ihit, dhit, CUdren, CUdwen, CUhalt, RST}
  task automatic drive(input logic [5:0] in);
    {ihit, dhit, CUdren, CUdwen, CUhalt, RST} = in;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    bit e_upc;
    e_upc = !m_halted && (m_busy ? dhit : (ihit && !CUhalt && !CUdren && !CUdwen));
    check1({tag, ".iren"}, iren, !m_halted && !m_busy);
    check1({tag, ".dren"}, dren, m_busy && !m_wr);
    check1({tag, ".dwen"}, dwen, m_busy && m_wr);
    check1({tag, ".updatePC"}, updatePC, e_upc);
    check1({tag, ".halt"}, halt, m_halted);
    check1({tag, ".timeout"}, timeout, m_to);
    checkw({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(m_cnt % (1 << IW)));
`ifdef REQ_PERF_CNT_EN
    checkw({tag, ".istall_cnt"}, istall_cnt, 32'(m_istall));
    checkw({tag, ".dstall_cnt"}, dstall_cnt, 32'(m_dstall));
`endif
  endtask

  typedef struct {
    logic [5:0] in;   // {ihit, dhit, CUdren, CUdwen, CUhalt, RST}
    logic [5:0] out;  // {iren, dren, dwen, updatePC, halt, timeout}
    int         cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [5:0] in, input logic [5:0] out, input int cnt);
    vec_t v;
    v.in = in; v.out = out; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [5:0] r;
    // Reset value, then five plain fetches.
    add(6'b000000, 6'b100000, 0);
    for (int i = 0; i < 5; i++) add(6'b100000, 6'b100100, i);
    add(6'b000000, 6'b100000, 5);
    // Load with dhit after three wait cycles.
    add(6'b101000, 6'b100000, 5);
    for (int i = 0; i < 3; i++) add(6'b000000, 6'b010000, 5);
    add(6'b010000, 6'b010100, 5);
    add(6'b000000, 6'b100000, 6);
    // ihit+dhit in IDLE: only ihit acts; lone dhit in IDLE ignored.
    add(6'b110000, 6'b100100, 6);
    add(6'b010000, 6'b100000, 7);
    // Both read and write requested: write wins; ihit/CUhalt ignored in DATA.
    add(6'b101100, 6'b100000, 7);
    add(6'b110010, 6'b001100, 7);
    add(6'b000000, 6'b100000, 8);
    // Write held 10 cycles: timeout appears after the 4th DATA cycle.
    add(6'b100100, 6'b100000, 8);
    for (int i = 0; i < 4; i++) add(6'b101000, 6'b001000, 8);
    for (int i = 0; i < 6; i++) add(6'b100010, 6'b001001, 8);
    add(6'b010000, 6'b001101, 8);
    add(6'b000000, 6'b100001, 9);
    add(6'b100000, 6'b100101, 9);
    // Halt is terminal; RST restores reset values.
    add(6'b101010, 6'b100001, 10);
    add(6'b101000, 6'b000011, 10);
    add(6'b110000, 6'b000011, 10);
    add(6'b100001, 6'b000011, 10);
    add(6'b000000, 6'b100000, 0);
    // Reset mid-request drops dren with no completion counted.
    add(6'b101000, 6'b100000, 0);
    add(6'b000001, 6'b010000, 0);
    add(6'b000000, 6'b100000, 0);

    drive(6'b000001);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      @(negedge CLK);
      r = vecs[i].out;
      check1($sformatf("vec%0d.iren", i), iren, r[5]);
      check1($sformatf("vec%0d.dren", i), dren, r[4]);
      check1($sformatf("vec%0d.dwen", i), dwen, r[3]);
      check1($sformatf("vec%0d.updatePC", i), updatePC, r[2]);
      check1($sformatf("vec%0d.halt", i), halt, r[1]);
      check1($sformatf("vec%0d.timeout", i), timeout, r[0]);
      checkw($sformatf("vec%0d.instr_cnt", i), 32'(instr_cnt), 32'(vecs[i].cnt));
      tick();
    end

    // Counter wrap at 2^IW.
    drive(6'b000001);
    tick();
    for (int i = 0; i < 255; i++) begin
      drive(6'b100000);
      tick();
    end
    drive(6'b000000);
    @(negedge CLK);
    checkw("wrap.before", 32'(instr_cnt), 32'd255);
    drive(6'b100000);
    tick();
    drive(6'b000000);
    @(negedge CLK);
    checkw("wrap.after", 32'(instr_cnt), 32'd0);

`ifdef REQ_PERF_CNT_EN
    drive(6'b000001);
    tick();
    drive(6'b000000); tick(); tick();
    drive(6'b101000); tick();
    drive(6'b000000); tick(); tick(); tick();
    drive(6'b010000); tick();
    drive(6'b000010);
    @(negedge CLK);
    checkw("perf.istall", istall_cnt, 32'd2);
    checkw("perf.dstall", dstall_cnt, 32'd3);
`endif

    // Random run against the model.
    drive(6'b000001);
    tick();
    for (int i = 0; i < 3000; i++) begin
      ihit   = ($urandom_range(0, 99) < 55);
      dhit   = ($urandom_range(0, 99) < 25);
      CUdren = ($urandom_range(0, 99) < 25);
      CUdwen = ($urandom_range(0, 99) < 20);
      CUhalt = ($urandom_range(0, 99) < 3);
      RST    = ($urandom_range(0, 99) < 2);
      @(negedge CLK);
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
